// File: rtl/sobel_edge_stream_if.sv
// VGA pixel-path bundle around the Sobel stage.
// Carries upstream timing plus gray in, and delayed timing plus RGB out.
interface sobel_edge_stream_if;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [7:0]  gray_in;

    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, gray_in,
        input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, gray_in,
        output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
    );
endinterface

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector on the VGA path, fixed 3-clock latency.
// Optional build macro SOBEL_GRAY_MAG_EN outputs graded magnitude instead of binary edges.
module sobel_edge_stream #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               enable,
    input  logic [7:0]         threshold,
    sobel_edge_stream_if.slave vga
);
    localparam int          AW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [7:0]  gray;
    } timing_t;

    logic [7:0]        lb0 [H_ACTIVE];
    logic [7:0]        lb1 [H_ACTIVE];
    logic [AW-1:0]     h_idx;
    logic              active;
    logic [7:0]        lb0_rd;
    logic [7:0]        lb1_rd;

    timing_t           t_in;
    timing_t           s1;
    timing_t           s2;

    logic [7:0]        win_top [3];
    logic [7:0]        win_mid [3];
    logic [7:0]        win_bot [3];

    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic [10:0]       abs_gx;
    logic [10:0]       abs_gy;
    logic [11:0]       mag;
    logic [7:0]        mag_sat;

    logic [7:0]        mag2;
    logic [7:0]        thr2;
    logic              en2;
    logic              frame_ok;

    logic              border;
    logic [11:0]       edge_hot;
    logic [11:0]       rgb_next;

    assign h_idx  = vga.hcount_in[AW-1:0];
    assign active = !vga.hblnk_in && !vga.vblnk_in && (vga.hcount_in < H_LIM);
    assign lb0_rd = lb0[h_idx];
    assign lb1_rd = lb1[h_idx];

    assign t_in = '{
        hcount: vga.hcount_in,
        vcount: vga.vcount_in,
        hsync:  vga.hsync_in,
        vsync:  vga.vsync_in,
        hblnk:  vga.hblnk_in,
        vblnk:  vga.vblnk_in,
        gray:   vga.gray_in
    };

    // Both line buffers are read combinationally before the write lands, so
    // lb1 receives the row that lb0 held one line earlier.
    always_ff @(posedge pclk) begin
        if (active) begin
            lb1[h_idx] <= lb0_rd;
            lb0[h_idx] <= vga.gray_in;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            s1 <= '0;
            for (int i = 0; i < 3; i++) begin
                win_top[i] <= '0;
                win_mid[i] <= '0;
                win_bot[i] <= '0;
            end
        end else begin
            s1 <= t_in;
            if (active) begin
                win_top[0] <= win_top[1];
                win_top[1] <= win_top[2];
                win_top[2] <= lb1_rd;
                win_mid[0] <= win_mid[1];
                win_mid[1] <= win_mid[2];
                win_mid[2] <= lb0_rd;
                win_bot[0] <= win_bot[1];
                win_bot[1] <= win_bot[2];
                win_bot[2] <= vga.gray_in;
            end
        end
    end

    function automatic logic signed [10:0] ext(input logic [7:0] p);
        return signed'({3'b000, p});
    endfunction

    // Column index 0 is west, 2 is east; row top is north.
    always_comb begin
        gx = (ext(win_top[2]) + (ext(win_mid[2]) <<< 1) + ext(win_bot[2]))
           - (ext(win_top[0]) + (ext(win_mid[0]) <<< 1) + ext(win_bot[0]));
        gy = (ext(win_bot[0]) + (ext(win_bot[1]) <<< 1) + ext(win_bot[2]))
           - (ext(win_top[0]) + (ext(win_top[1]) <<< 1) + ext(win_top[2]));
        abs_gx  = gx[10] ? $unsigned(-gx) : $unsigned(gx);
        abs_gy  = gy[10] ? $unsigned(-gy) : $unsigned(gy);
        mag     = {1'b0, abs_gx} + {1'b0, abs_gy};
        mag_sat = (mag > 12'd255) ? 8'hFF : mag[7:0];
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            s2   <= '0;
            mag2 <= '0;
            thr2 <= '0;
            en2  <= 1'b0;
        end else begin
            s2   <= s1;
            mag2 <= mag_sat;
            thr2 <= threshold;
            en2  <= enable;
        end
    end

    // Edge output is held black until a fresh frame has filled the line buffers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_ok <= 1'b0;
        end else if (s1.vblnk && !vga.vblnk_in) begin
            frame_ok <= 1'b1;
        end
    end

`ifdef SOBEL_GRAY_MAG_EN
    assign edge_hot = {mag2[7:4], mag2[7:4], mag2[7:4]};
`else
    assign edge_hot = 12'hFFF;
`endif

    always_comb begin
        border = (s2.hcount < 11'd2) || (s2.hcount >= H_LIM)
              || (s2.vcount < 11'd2) || (s2.vcount >= V_LIM);
        rgb_next = 12'h000;
        if (s2.hblnk || s2.vblnk) begin
            rgb_next = 12'h000;
        end else if (!en2) begin
            rgb_next = {s2.gray[7:4], s2.gray[7:4], s2.gray[7:4]};
        end else if (border || !frame_ok) begin
            rgb_next = 12'h000;
        end else if (mag2 >= thr2) begin
            rgb_next = edge_hot;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vga.hcount_out <= '0;
            vga.vcount_out <= '0;
            vga.hsync_out  <= 1'b0;
            vga.vsync_out  <= 1'b0;
            vga.hblnk_out  <= 1'b0;
            vga.vblnk_out  <= 1'b0;
            vga.rgb_out    <= '0;
        end else begin
            vga.hcount_out <= s2.hcount;
            vga.vcount_out <= s2.vcount;
            vga.hsync_out  <= s2.hsync;
            vga.vsync_out  <= s2.vsync;
            vga.hblnk_out  <= s2.hblnk;
            vga.vblnk_out  <= s2.vblnk;
            vga.rgb_out    <= rgb_next;
        end
    end
endmodule

// File: tb/tb_sobel_edge_stream.sv
// Directed bench for sobel_edge_stream on a shrunken 16x8 raster with a 22x11 total frame.
// Expected edge magnitudes per pattern are worked out by hand in hand_mag().
`timescale 1ns/1ps
module tb_sobel_edge_stream;
    localparam int H_ACTIVE = 16;
    localparam int V_ACTIVE = 8;
    localparam int H_TOTAL  = 22;
    localparam int V_TOTAL  = 11;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    typedef enum logic [1:0] {PAT_FLAT, PAT_STEP, PAT_CHECK, PAT_RAMP} pat_t;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [7:0]  g;
        logic        en;
        logic [7:0]  thr;
        logic        fok;
        pat_t        pat;
    } entry_t;

    logic       pclk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] threshold;

    sobel_edge_stream_if vga();

    sobel_edge_stream #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .enable    (enable),
        .threshold (threshold),
        .vga       (vga)
    );

    always #20 pclk = ~pclk;

    int     h_cnt;
    int     v_cnt;
    pat_t   pat;
    entry_t cur;
    entry_t hist [3];
    logic   seen_vb;
    logic   fok_b;
    int     n_checks = 0;
    int     n_fails  = 0;

    // Edge magnitude at an interior centre, derived by hand for each pattern.
    function automatic logic [7:0] hand_mag(input pat_t p, input int h);
        case (p)
            PAT_STEP: return (h == 8 || h == 9) ? 8'd255 : 8'd0;
            PAT_RAMP: return 8'd128;
            default:  return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] pat_gray(input pat_t p, input int h, input int v);
        if (h >= H_ACTIVE) return 8'd0;
        case (p)
            PAT_FLAT:  return 8'h80;
            PAT_STEP:  return (h < 8) ? 8'd0 : 8'd255;
            PAT_CHECK: return (((h ^ v) & 1) != 0) ? 8'd255 : 8'd0;
            default:   return 8'(h * 16);
        endcase
    endfunction

    function automatic logic [11:0] exp_rgb(input entry_t p, input logic en, input logic [7:0] thr);
        logic [7:0] m;
        if (p.hb || p.vb) return 12'h000;
        if (!en) return {p.g[7:4], p.g[7:4], p.g[7:4]};
        if (int'(p.h) < 2 || int'(p.h) >= H_ACTIVE || int'(p.v) < 2 || int'(p.v) >= V_ACTIVE)
            return 12'h000;
        if (!p.fok) return 12'h000;
        m = hand_mag(p.pat, int'(p.h));
        if (m < thr) return 12'h000;
`ifdef SOBEL_GRAY_MAG_EN
        return {m[7:4], m[7:4], m[7:4]};
`else
        return 12'hFFF;
`endif
    endfunction

    task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h (input h=%0d v=%0d)",
                   tag, obs, exp, hist[2].h, hist[2].v);
        end
    endtask

    task automatic check_output();
        entry_t p;
        p = hist[2];
        check_val("hcount_out", {1'b0, vga.hcount_out}, {1'b0, p.h});
        check_val("vcount_out", {1'b0, vga.vcount_out}, {1'b0, p.v});
        check_val("hsync_out", {11'd0, vga.hsync_out}, {11'd0, p.hs});
        check_val("vsync_out", {11'd0, vga.vsync_out}, {11'd0, p.vs});
        check_val("hblnk_out", {11'd0, vga.hblnk_out}, {11'd0, p.hb});
        check_val("vblnk_out", {11'd0, vga.vblnk_out}, {11'd0, p.vb});
        check_val("rgb_out", vga.rgb_out, exp_rgb(p, hist[1].en, hist[1].thr));
    endtask

    task automatic apply_stimulus();
        cur.h   = 11'(h_cnt);
        cur.v   = 11'(v_cnt);
        cur.hb  = (h_cnt >= H_ACTIVE);
        cur.vb  = (v_cnt >= V_ACTIVE);
        cur.hs  = (h_cnt == 17 || h_cnt == 18);
        cur.vs  = (v_cnt == 9);
        cur.g   = pat_gray(pat, h_cnt, v_cnt);
        cur.en  = enable;
        cur.thr = threshold;
        cur.pat = pat;
        cur.fok = 1'b0;
        vga.hcount_in = cur.h;
        vga.vcount_in = cur.v;
        vga.hsync_in  = cur.hs;
        vga.vsync_in  = cur.vs;
        vga.hblnk_in  = cur.hb;
        vga.vblnk_in  = cur.vb;
        vga.gray_in   = cur.g;
    endtask

    task automatic advance();
        h_cnt++;
        if (h_cnt == H_TOTAL) begin
            h_cnt = 0;
            v_cnt = (v_cnt == V_TOTAL - 1) ? 0 : v_cnt + 1;
        end
    endtask

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus();
            if (cur.vb) seen_vb = 1'b1;
            else if (seen_vb) fok_b = 1'b1;
            cur.fok = fok_b;
            @(posedge pclk);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = cur;
            advance();
            #1;
            check_output();
        end
    endtask

    // One-cycle reset while the raster keeps running; everything in flight becomes zero.
    task automatic do_reset();
        apply_stimulus();
        rst = 1'b1;
        @(posedge pclk);
        hist[0] = '0;
        hist[1] = '0;
        hist[2] = '0;
        seen_vb = 1'b0;
        fok_b   = 1'b0;
        advance();
        #1;
        rst = 1'b0;
        check_output();
    endtask

    task automatic goto_line(input int v);
        for (int i = 0; i < 2 * FRAME && !(h_cnt == 0 && v_cnt == v); i++) begin
            step_cycles(1);
        end
    endtask

    initial begin
        rst       = 1'b0;
        enable    = 1'b1;
        threshold = 8'd10;
        pat       = PAT_FLAT;
        h_cnt     = 0;
        v_cnt     = V_ACTIVE;
        seen_vb   = 1'b0;
        fok_b     = 1'b0;

        $display("[TB] reset, flat gray 0x80, threshold 10");
        do_reset();
        goto_line(V_ACTIVE);
        step_cycles(FRAME);

        $display("[TB] vertical step, threshold 200");
        pat       = PAT_STEP;
        threshold = 8'd200;
        step_cycles(FRAME);

        $display("[TB] vertical step, bypass");
        enable = 1'b0;
        step_cycles(FRAME);

        $display("[TB] mid-line enable and threshold changes");
        enable = 1'b1;
        goto_line(3);
        step_cycles(9);
        enable = 1'b0;
        step_cycles(2);
        enable = 1'b1;
        step_cycles(1);
        threshold = 8'd255;
        step_cycles(3);
        threshold = 8'd0;
        step_cycles(4);
        threshold = 8'd200;
        goto_line(V_ACTIVE);

        $display("[TB] checkerboard, threshold 255 then 0");
        pat       = PAT_CHECK;
        threshold = 8'd255;
        step_cycles(FRAME);
        threshold = 8'd0;
        step_cycles(FRAME);

        $display("[TB] ramp, threshold 128 then 129");
        pat       = PAT_RAMP;
        threshold = 8'd128;
        step_cycles(FRAME);
        threshold = 8'd129;
        step_cycles(FRAME);

        $display("[TB] reset mid-frame in edge mode");
        pat       = PAT_STEP;
        threshold = 8'd200;
        goto_line(4);
        step_cycles(5);
        do_reset();
        goto_line(V_ACTIVE);
        step_cycles(FRAME);

        $display("[TB] reset mid-frame in bypass mode");
        goto_line(5);
        enable = 1'b0;
        do_reset();
        step_cycles(2 * H_TOTAL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
